// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA controller slice.
//   - Transfer geometry: word/block widths, blocks per transfer, bus hold time.
//   - State encoding of the controller FSM.
//   - blk_start(): rewinds a cycle count to the first cycle of its block.
package dma_controller_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int FETCH_SIZE    = 64;
    localparam int NUM_BLOCKS    = 3;
    localparam int MEM_LATENCY   = 4;

    localparam int WORDS_PER_BLK = FETCH_SIZE / WORD_SIZE;
    localparam int XFER_CYCLES   = NUM_BLOCKS * MEM_LATENCY;
    // One extra code so the one-ahead count (XFER_CYCLES) is representable.
    localparam int CNT_W         = $clog2(XFER_CYCLES + 1);
    localparam int IDX_W         = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } dma_state_t;

    function automatic logic [CNT_W-1:0] blk_start(input logic [CNT_W-1:0] cnt);
        return (cnt / CNT_W'(MEM_LATENCY)) * CNT_W'(MEM_LATENCY);
    endfunction

endpackage

// File: rtl/dma_controller_if.sv
// CPU/memory-side bundle of the DMA controller.
//   master (DMA engine): drives BR, dma_end, d_writeM, d_address, d_data, dev_idx;
//                        receives cmd, dma_base, BG, dev_data.
//   slave  (CPU/system): the mirror image.
interface dma_controller_if;
    import dma_controller_pkg::*;

    logic                  cmd;
    logic [WORD_SIZE-1:0]  dma_base;
    logic                  BG;
    logic                  BR;
    logic                  dma_end;
    logic                  d_writeM;
    logic [WORD_SIZE-1:0]  d_address;
    logic [FETCH_SIZE-1:0] d_data;
    logic [IDX_W-1:0]      dev_idx;
    logic [FETCH_SIZE-1:0] dev_data;

    modport master (
        input  cmd, dma_base, BG, dev_data,
        output BR, dma_end, d_writeM, d_address, d_data, dev_idx
    );

    modport slave (
        output cmd, dma_base, BG, dev_data,
        input  BR, dma_end, d_writeM, d_address, d_data, dev_idx
    );

endinterface

// File: rtl/dma_controller_addr_gen.sv
// dma_addr_gen: combinational address/index generation for the DMA engine.
//   i_base    : block-aligned destination word address
//   i_cnt     : transfer cycle count that will be presented on the bus
//   i_ahead   : 1 when i_cnt is being written, so the device buffer should
//               already be pointed at the block of the following cycle
//   o_address : i_base + WORDS_PER_BLK * (i_cnt / MEM_LATENCY), wraps at 2^16
//   o_dev_idx : block index the device buffer must present next
module dma_addr_gen
    import dma_controller_pkg::*;
(
    input  logic [WORD_SIZE-1:0] i_base,
    input  logic [CNT_W-1:0]     i_cnt,
    input  logic                 i_ahead,
    output logic [WORD_SIZE-1:0] o_address,
    output logic [IDX_W-1:0]     o_dev_idx
);

    logic [IDX_W-1:0] w_blk;
    logic [CNT_W-1:0] w_cnt_ahead;

    assign w_blk       = IDX_W'(i_cnt / CNT_W'(MEM_LATENCY));
    // Unsigned add truncated to WORD_SIZE gives the modulo-2^16 wrap.
    assign o_address   = i_base + WORD_SIZE'(w_blk) * WORD_SIZE'(WORDS_PER_BLK);

    // dev_data is a combinational read of the registered dev_idx, so the index
    // has to lead the data register by one cycle.  Past the last block there is
    // nothing left to fetch; park on block 0 for the next transfer.
    assign w_cnt_ahead = i_cnt + CNT_W'(i_ahead);
    assign o_dev_idx   = (w_cnt_ahead < CNT_W'(XFER_CYCLES))
                       ? IDX_W'(w_cnt_ahead / CNT_W'(MEM_LATENCY)) : '0;

endmodule

// File: rtl/dma_controller.sv
// dma_controller: bus-master DMA engine behind the CPU BR/BG/cmd/dma_end handshake.
// On a rising edge of cmd it requests the bus, and under grant writes NUM_BLOCKS
// FETCH_SIZE-bit blocks from the device buffer to memory, holding each block on
// the bus for MEM_LATENCY granted cycles, then pulses dma_end for one cycle.
//   Clk     : system clock, rising edge
//   Reset_N : asynchronous active-low reset
//   bus     : dma_controller_if.master (cmd, dma_base, BG, dev_data in;
//             BR, dma_end, d_writeM, d_address, d_data, dev_idx out)
module dma_controller
    import dma_controller_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_N,
    dma_controller_if.master bus
);

    dma_state_t            r_state;
    dma_state_t            w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_wr_nxt;
    logic [WORD_SIZE-1:0]  r_base;
    logic                  r_cmd_q;
    logic                  w_start;
    logic                  r_br;
    logic                  r_dma_end;
    logic                  r_writeM;
    logic [WORD_SIZE-1:0]  r_address;
    logic [FETCH_SIZE-1:0] r_data;
    logic [IDX_W-1:0]      r_dev_idx;
    logic [WORD_SIZE-1:0]  w_address;
    logic [IDX_W-1:0]      w_dev_idx;

    assign w_start = bus.cmd & ~r_cmd_q;

    dma_addr_gen u_addr_gen (
        .i_base    (r_base),
        .i_cnt     (w_cnt_nxt),
        .i_ahead   (w_wr_nxt),
        .o_address (w_address),
        .o_dev_idx (w_dev_idx)
    );

    // State register
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = REQ;
            REQ:  if (bus.BG)  w_state_nxt = XFER;
            XFER: if (bus.BG && r_writeM && (r_cnt == CNT_W'(XFER_CYCLES - 1)))
                      w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output/counter logic.  In XFER, r_writeM=0 means paused on a lost grant;
    // r_cnt then already points at the first cycle of the block to redo.
    always_comb begin
        w_cnt_nxt = '0;
        w_wr_nxt  = 1'b0;
        case (r_state)
            REQ: begin
                if (bus.BG) w_wr_nxt = 1'b1;
            end
            XFER: begin
                w_cnt_nxt = r_cnt;
                if (bus.BG) begin
                    if (!r_writeM) begin
                        w_wr_nxt = 1'b1;
                    end else if (r_cnt != CNT_W'(XFER_CYCLES - 1)) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        w_wr_nxt  = 1'b1;
                    end
                end else if (r_writeM) begin
                    w_cnt_nxt = blk_start(r_cnt);
                end
            end
            default: begin
                w_cnt_nxt = '0;
                w_wr_nxt  = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_cnt     <= '0;
            r_base    <= '0;
            r_cmd_q   <= 1'b0;
            r_br      <= 1'b0;
            r_dma_end <= 1'b0;
            r_writeM  <= 1'b0;
            r_address <= '0;
            r_data    <= '0;
            r_dev_idx <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_cmd_q   <= bus.cmd;
            r_br      <= (w_state_nxt == REQ) || (w_state_nxt == XFER);
            r_dma_end <= (w_state_nxt == DONE);
            r_writeM  <= w_wr_nxt;
            r_dev_idx <= (w_state_nxt == XFER) ? w_dev_idx : '0;
            if ((r_state == IDLE) && w_start) begin
                r_base <= bus.dma_base & ~WORD_SIZE'(WORDS_PER_BLK - 1);
            end
            if (w_wr_nxt) begin
                r_address <= w_address;
                r_data    <= bus.dev_data;
            end
        end
    end

    assign bus.BR        = r_br;
    assign bus.dma_end   = r_dma_end;
    assign bus.d_writeM  = r_writeM;
    assign bus.d_address = r_address;
    assign bus.d_data    = r_data;
    assign bus.dev_idx   = r_dev_idx;

endmodule

// File: tb/tb_dma_controller.sv
// Directed testbench for dma_controller.
module tb_dma_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int errors = 0;
    int checks = 0;

    dma_controller_if bus ();

    dma_controller dut (
        .Clk     (clk),
        .Reset_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] dev_buf [4] = '{64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD,
                                 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_DEAD_BEEF};
    assign bus.dev_data = dev_buf[bus.dev_idx];

    logic [15:0] addr_basic [3] = '{16'h01F0, 16'h01F4, 16'h01F8};
    logic [15:0] addr_wrap  [3] = '{16'hFFF8, 16'hFFFC, 16'h0000};
    int          drop_blk  [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2};

    // Transfer observations
    logic [15:0] wr_addr [32];
    logic [63:0] wr_data [32];
    int   nw, n_end, n_overlap, wm_no_bg, br_low, gap_writes, post_br;
    logic end_br;
    bit   timed_out;

    // Runs one transfer and records what the DUT put on the bus.
    task automatic run_transfer(input logic [15:0] base, input int grant_delay,
                                input int drop_at, input int drop_len,
                                input int pulse_at, input bit hold_cmd);
        int br_wait = 0;
        int gap = 0;
        int post = 0;
        bit granted = 0, dropping = 0, dropped = 0, ended = 0, br_up = 0;
        for (int i = 0; i < 32; i++) begin
            wr_addr[i] = '0;
            wr_data[i] = '0;
        end
        nw = 0; n_end = 0; n_overlap = 0; wm_no_bg = 0; br_low = 0;
        gap_writes = 0; post_br = 0; end_br = 1'b1; timed_out = 0;
        @(negedge clk);
        bus.dma_base = base;
        bus.cmd      = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (bus.d_writeM) begin
                if (nw < 32) begin
                    wr_addr[nw] = bus.d_address;
                    wr_data[nw] = bus.d_data;
                end
                nw++;
                if (!bus.BG) wm_no_bg++;
            end
            if (bus.dma_end) begin
                n_end++;
                if (!ended) end_br = bus.BR;
                if (bus.d_writeM) n_overlap++;
            end
            if (ended) begin
                if (bus.BR) post_br++;
                post++;
                if (post == 3) break;
                continue;
            end
            if (bus.dma_end) begin
                ended  = 1;
                bus.BG = 1'b0;
                if (!hold_cmd) bus.cmd = 1'b0;
                continue;
            end
            if (bus.BR) br_up = 1;
            else if (br_up) br_low++;
            if (dropping) begin
                gap++;
                if (bus.d_writeM) gap_writes++;
                if (gap == drop_len) begin
                    bus.BG   = 1'b1;
                    dropping = 0;
                end
            end else if (bus.d_writeM && nw == drop_at && !dropped) begin
                bus.BG   = 1'b0;
                dropping = 1;
                dropped  = 1;
            end
            if (bus.d_writeM && nw == pulse_at)     bus.cmd = 1'b0;
            if (bus.d_writeM && nw == pulse_at + 1) bus.cmd = 1'b1;
            if (bus.BR && !granted) begin
                if (br_wait == grant_delay) begin
                    bus.BG  = 1'b1;
                    granted = 1;
                end
                br_wait++;
            end
        end
        if (!ended) timed_out = 1;
        bus.BG = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd = 1'b0; bus.BG = 1'b0; bus.dma_base = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.BR !== 1'b0) begin errors++; $display("FAIL reset_BR: got %b expected 0", bus.BR); end
        checks++; if (bus.dma_end !== 1'b0) begin errors++; $display("FAIL reset_dma_end: got %b expected 0", bus.dma_end); end
        checks++; if (bus.d_writeM !== 1'b0) begin errors++; $display("FAIL reset_d_writeM: got %b expected 0", bus.d_writeM); end
        checks++; if (bus.d_address !== 16'h0000) begin errors++; $display("FAIL reset_d_address: got %h expected 0000", bus.d_address); end
        checks++; if (bus.d_data !== 64'h0) begin errors++; $display("FAIL reset_d_data: got %h expected 0", bus.d_data); end
        checks++; if (bus.dev_idx !== 2'd0) begin errors++; $display("FAIL reset_dev_idx: got %0d expected 0", bus.dev_idx); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_transfer(16'h01F2, 2, -1, 0, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no dma_end expected dma_end"); end
        checks++; if (nw !== 12) begin errors++; $display("FAIL basic_writes: got %0d expected 12", nw); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (wr_addr[i] !== addr_basic[i/4] || wr_data[i] !== dev_buf[i/4]) begin
                errors++;
                $display("FAIL basic_word%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], addr_basic[i/4], dev_buf[i/4]);
            end
        end
        checks++; if (n_end !== 1) begin errors++; $display("FAIL basic_dma_end_pulses: got %0d expected 1", n_end); end
        checks++; if (end_br !== 1'b0) begin errors++; $display("FAIL basic_BR_at_end: got %b expected 0", end_br); end
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL basic_end_write_overlap: got %0d expected 0", n_overlap); end
    endtask

    task automatic test_delayed_grant();
        run_transfer(16'h01F2, 20, -1, 0, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL delay_timeout: got no dma_end expected dma_end"); end
        checks++; if (br_low !== 0) begin errors++; $display("FAIL delay_BR_held: got %0d low cycles expected 0", br_low); end
        checks++; if (wm_no_bg !== 0) begin errors++; $display("FAIL delay_write_without_grant: got %0d expected 0", wm_no_bg); end
        checks++; if (nw !== 12) begin errors++; $display("FAIL delay_writes: got %0d expected 12", nw); end
        checks++; if (n_end !== 1) begin errors++; $display("FAIL delay_dma_end_pulses: got %0d expected 1", n_end); end
    endtask

    task automatic test_grant_drop();
        run_transfer(16'h01F2, 0, 6, 3, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL drop_timeout: got no dma_end expected dma_end"); end
        checks++; if (gap_writes !== 0) begin errors++; $display("FAIL drop_gap_writes: got %0d expected 0", gap_writes); end
        checks++; if (br_low !== 0) begin errors++; $display("FAIL drop_BR_held: got %0d low cycles expected 0", br_low); end
        checks++; if (nw !== 14) begin errors++; $display("FAIL drop_writes: got %0d expected 14", nw); end
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (wr_addr[i] !== addr_basic[drop_blk[i]] || wr_data[i] !== dev_buf[drop_blk[i]]) begin
                errors++;
                $display("FAIL drop_word%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], addr_basic[drop_blk[i]], dev_buf[drop_blk[i]]);
            end
        end
        checks++; if (n_end !== 1) begin errors++; $display("FAIL drop_dma_end_pulses: got %0d expected 1", n_end); end
    endtask

    task automatic test_retrigger();
        int br_seen = 0;
        run_transfer(16'h01F2, 1, -1, 0, 3, 1);
        checks++; if (timed_out) begin errors++; $display("FAIL retrig_timeout: got no dma_end expected dma_end"); end
        checks++; if (nw !== 12) begin errors++; $display("FAIL retrig_writes: got %0d expected 12", nw); end
        checks++; if (n_end !== 1) begin errors++; $display("FAIL retrig_dma_end_pulses: got %0d expected 1", n_end); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.BR) br_seen++;
        end
        checks++; if (post_br + br_seen !== 0) begin errors++; $display("FAIL retrig_held_cmd_BR: got %0d BR cycles expected 0", post_br + br_seen); end
        bus.cmd = 1'b0;
        @(negedge clk);
        run_transfer(16'h01F2, 0, -1, 0, -1, 0);
        checks++; if (nw !== 12 || timed_out) begin errors++; $display("FAIL retrig_new_edge_writes: got %0d expected 12", nw); end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        bit hit = 0;
        @(negedge clk);
        bus.dma_base = 16'h01F2;
        bus.cmd      = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (bus.d_writeM) cnt++;
            if (cnt == 6) begin hit = 1; break; end
            if (bus.BR) bus.BG = 1'b1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_cnt5: got %0d writes expected 6", cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.BR !== 1'b0) begin errors++; $display("FAIL rstmid_BR: got %b expected 0", bus.BR); end
        checks++; if (bus.d_writeM !== 1'b0) begin errors++; $display("FAIL rstmid_d_writeM: got %b expected 0", bus.d_writeM); end
        checks++; if (bus.dma_end !== 1'b0) begin errors++; $display("FAIL rstmid_dma_end: got %b expected 0", bus.dma_end); end
        bus.BG = 1'b0; bus.cmd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.BR !== 1'b0 || bus.d_writeM !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after: got BR=%b wr=%b expected 0/0", bus.BR, bus.d_writeM); end
        run_transfer(16'h01F2, 0, -1, 0, -1, 0);
        checks++; if (nw !== 12 || timed_out) begin errors++; $display("FAIL rstmid_full_transfer: got %0d writes expected 12", nw); end
        checks++; if (wr_addr[11] !== 16'h01F8) begin errors++; $display("FAIL rstmid_last_addr: got %h expected 01F8", wr_addr[11]); end
    endtask

    task automatic test_wrap();
        run_transfer(16'hFFF9, 0, -1, 0, -1, 0);
        checks++; if (nw !== 12 || timed_out) begin errors++; $display("FAIL wrap_writes: got %0d expected 12", nw); end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (wr_addr[4*b] !== addr_wrap[b] || wr_addr[4*b+3] !== addr_wrap[b]) begin
                errors++;
                $display("FAIL wrap_block%0d: got %h..%h expected %h", b, wr_addr[4*b], wr_addr[4*b+3], addr_wrap[b]);
            end
        end
    endtask

    task automatic test_idle_grant();
        int act = 0;
        bus.cmd = 1'b0;
        bus.BG  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.d_writeM || bus.BR || bus.dma_end) act++;
        end
        bus.BG = 1'b0;
        checks++; if (act !== 0) begin errors++; $display("FAIL idle_grant_activity: got %0d cycles expected 0", act); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delayed_grant();
        test_grant_drop();
        test_retrigger();
        test_reset_mid();
        test_wrap();
        test_idle_grant();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
